key_set_ctrl: RTL and testbench
===============================

KEY_SET_CTRL -- requirements
Module: key_set_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMEOUT_S, 10, inactivity timeout in tick_1hz pulses.
- BLINK_HALF, 12_500_000, clk cycles per blink half-period.
- REPEAT_DELAY, 25_000_000, held-key cycles before the first auto-repeat.
- REPEAT_RATE, 5_000_000, cycles between auto-repeats.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, 50MHz main clock; one clock, all logic on rising edge.
- rst, in, 1, reset, synchronous, active-high.
- key_mode_pulse, in, 1, debounced single-cycle mode key press.
- key_up_pulse, in, 1, debounced single-cycle up key press.
- key_down_pulse, in, 1, debounced single-cycle down key press.
- key_up_held, in, 1, debounced up key level, 1 = held.
- key_down_held, in, 1, debounced down key level, 1 = held.
- tick_1hz, in, 1, single-cycle 1 Hz timebase pulse.
- set_mode, out, 2, 0 = NORMAL, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC.
- adj_inc, out, 1, single-cycle increment command for the selected field.
- adj_dec, out, 1, single-cycle decrement command for the selected field.
- run_en, out, 1, seconds counting enable.
- blink, out, 1, display enable for the selected field.

Function
REQ-003 The FSM SHALL cycle NORMAL -> SET_HOUR -> SET_MIN -> SET_SEC -> NORMAL, advancing one state per key_mode_pulse, with the state registered so the new set_mode appears the cycle after the pulse.
REQ-004 Simultaneous pulses SHALL be resolved with priority mode > up > down, and only one action SHALL be taken per cycle.
REQ-005 In a set state, key_up_pulse SHALL produce adj_inc=1 for exactly one cycle, the cycle after the pulse; key_down_pulse SHALL produce adj_dec the same way.
REQ-006 adj_inc and adj_dec SHALL never be high in the same cycle.
REQ-007 In NORMAL, up/down pulses and held levels SHALL be ignored.
REQ-008 run_en SHALL be 0 in SET_SEC and 1 in all other states.
REQ-009 Inactivity counter: any key pulse or state change SHALL clear it; in set states each tick_1hz SHALL increment it.
REQ-010 When the inactivity counter reaches TIMEOUT_S, the FSM SHALL return to NORMAL on the next cycle.
REQ-011 A key pulse coincident with the timeout tick SHALL win: the pulse is processed and the counter is cleared.
REQ-012 blink SHALL be 1 in NORMAL; in a set state it SHALL toggle every BLINK_HALF cycles.
REQ-013 On every set-state entry the blink counter SHALL be cleared and blink forced to 1.
REQ-014 The blink counter SHALL wrap to 0 at BLINK_HALF-1, with no overflow at any parameter value up to 2^26.
REQ-015 A mode change while adj_inc/adj_dec is high SHALL not extend or repeat that pulse.

Reset
REQ-016 When rst=1 at a clock edge, the outputs SHALL take set_mode=0, adj_inc=0, adj_dec=0, run_en=1, blink=1.
REQ-017 Reset SHALL clear all counters, including the inactivity, blink and repeat counters.
REQ-018 rst SHALL take priority over all inputs, and reset mid-adjust SHALL discard any pending repeat.

Configuration
REQ-019 With macro KEY_SET_AUTO_REPEAT_EN defined, repeat SHALL start with a press in a set state; if the held level stays high for REPEAT_DELAY cycles, one adj_inc/adj_dec SHALL follow, then one more every REPEAT_RATE cycles while held.
REQ-020 With the macro defined, key release, a mode change or a timeout SHALL stop repeating and clear the repeat counter.
REQ-021 With the macro defined, every repeat pulse SHALL also clear the inactivity counter.
REQ-022 Without the macro, key_up_held and key_down_held SHALL be ignored and no repeat logic SHALL be synthesized.

Verification
REQ-023 The bench SHALL cover these scenarios, all with TIMEOUT_S=3, BLINK_HALF=4, REPEAT_DELAY=10, REPEAT_RATE=3:
- Reset then 4 mode pulses -> set_mode goes 1, 2, 3, 0, each one cycle after its pulse; run_en=0 only while set_mode=3.
- In SET_MIN, mode and up pulses in the same cycle -> set_mode=3 and no adj_inc.
- In SET_HOUR, 3 tick_1hz with no keys -> set_mode=0 one cycle after the 3rd tick; an up pulse on the 3rd tick instead -> adj_inc, mode stays 1.
- In SET_HOUR, blink samples 1,1,1,1,0,0,0,0,1; blink=1 in NORMAL; adj_inc low for any up pulse in NORMAL.
- With macro: up pulse then held 20 cycles in SET_MIN -> adj_inc 1 cycle after the pulse, then 10 cycles after the press, then every 3 cycles; stops on release.
- rst asserted while repeating -> all outputs at reset values next cycle, with no further adj_inc.

Source files
------------

// File: rtl/key_set_ctrl.sv
// key_set_ctrl: clock-setting key controller with mode/up/down FSM, inactivity timeout and field blink.
// Define KEY_SET_AUTO_REPEAT_EN to build auto-repeat of held up/down keys.
module key_set_ctrl #(
   parameter int TIMEOUT_S    = 10,
   parameter int BLINK_HALF   = 12_500_000,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode_pulse,
   input  logic       key_up_pulse,
   input  logic       key_down_pulse,
   input  logic       key_up_held,
   input  logic       key_down_held,
   input  logic       tick_1hz,
   output logic [1:0] set_mode,
   output logic       adj_inc,
   output logic       adj_dec,
   output logic       run_en,
   output logic       blink
);

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } mode_e;

   localparam int IW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   mode_e         state_q, state_d;
   logic          inc_d, dec_d;
   logic [IW-1:0] inact_q, inact_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic          in_set, any_pulse, timeout;
   logic          rep_fire, rep_up;

   assign in_set    = (state_q != NORMAL);
   assign any_pulse = key_mode_pulse | key_up_pulse | key_down_pulse;
   assign timeout   = in_set && tick_1hz && (inact_q == IW'(TIMEOUT_S - 1));

`ifdef KEY_SET_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic          rep_active_q, rep_up_q, rep_first_q, rep_held;
   logic [RW-1:0] rep_cnt_q;

   assign rep_held = rep_up_q ? key_up_held : key_down_held;
   assign rep_up   = rep_up_q;
   // Any fresh key pulse outranks a due repeat; the count restarts from that press.
   assign rep_fire = in_set && rep_active_q && rep_held && !any_pulse &&
                     (rep_first_q ? (rep_cnt_q >= RW'(REPEAT_DELAY - 1))
                                  : (rep_cnt_q >= RW'(REPEAT_RATE - 1)));

   always_ff @(posedge clk) begin
      if (rst || !in_set || (state_d != state_q)) begin
         rep_active_q <= 1'b0;
         rep_up_q     <= 1'b0;
         rep_first_q  <= 1'b0;
         rep_cnt_q    <= '0;
      end else if (key_up_pulse || key_down_pulse) begin
         rep_active_q <= 1'b1;
         rep_up_q     <= key_up_pulse;
         rep_first_q  <= 1'b1;
         rep_cnt_q    <= RW'(1);
      end else if (rep_active_q && !rep_held) begin
         rep_active_q <= 1'b0;
         rep_first_q  <= 1'b0;
         rep_cnt_q    <= '0;
      end else if (rep_fire) begin
         rep_first_q  <= 1'b0;
         rep_cnt_q    <= '0;
      end else if (rep_active_q) begin
         rep_cnt_q    <= rep_cnt_q + RW'(1);
      end
   end
`else
   localparam int unused_rep_params = REPEAT_DELAY + REPEAT_RATE;
   logic unused_held;
   assign unused_held = key_up_held | key_down_held;
   assign rep_fire    = 1'b0;
   assign rep_up      = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d     = state_q;
      inc_d       = 1'b0;
      dec_d       = 1'b0;
      inact_d     = inact_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;

      if (key_mode_pulse)              state_d = mode_e'(state_q + 2'd1);
      else if (in_set && key_up_pulse)   inc_d = 1'b1;
      else if (in_set && key_down_pulse) dec_d = 1'b1;
      else if (rep_fire) begin
         inc_d = rep_up;
         dec_d = !rep_up;
      end else if (timeout)            state_d = NORMAL;

      if ((state_d == NORMAL) || (state_d != state_q) || any_pulse || rep_fire)
         inact_d = '0;
      else if (tick_1hz)
         inact_d = inact_q + IW'(1);

      // Entering any set state restarts the blink phase with the field visible.
      if ((state_d == NORMAL) || (state_d != state_q)) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_d     = !blink_q;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= NORMAL;
         adj_inc     <= 1'b0;
         adj_dec     <= 1'b0;
         inact_q     <= '0;
         blink_q     <= 1'b1;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         adj_inc     <= inc_d;
         adj_dec     <= dec_d;
         inact_q     <= inact_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign set_mode = state_q;
   assign run_en   = (state_q != SET_SEC);
   assign blink    = blink_q;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Directed self-checking bench for key_set_ctrl (small timing parameters).
// Repeat expectations follow KEY_SET_AUTO_REPEAT_EN, matching the RTL build.
module tb_key_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_mode_pulse, key_up_pulse, key_down_pulse;
   logic       key_up_held, key_down_held, tick_1hz;
   logic [1:0] set_mode;
   logic       adj_inc, adj_dec, run_en, blink;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef KEY_SET_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   key_set_ctrl #(
      .TIMEOUT_S    (3),
      .BLINK_HALF   (4),
      .REPEAT_DELAY (10),
      .REPEAT_RATE  (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .key_mode_pulse (key_mode_pulse),
      .key_up_pulse   (key_up_pulse),
      .key_down_pulse (key_down_pulse),
      .key_up_held    (key_up_held),
      .key_down_held  (key_down_held),
      .tick_1hz       (tick_1hz),
      .set_mode       (set_mode),
      .adj_inc        (adj_inc),
      .adj_dec        (adj_dec),
      .run_en         (run_en),
      .blink          (blink)
   );

   // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      key_mode_pulse = 1'b0;
      key_up_pulse   = 1'b0;
      key_down_pulse = 1'b0;
      key_up_held    = 1'b0;
      key_down_held  = 1'b0;
      tick_1hz       = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic mode_pulse();
      key_mode_pulse = 1'b1;
      cyc();
      key_mode_pulse = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst            = 1'b1;
      key_mode_pulse = 1'b1;
      key_up_pulse   = 1'b1;
      cyc();
      rst = 1'b0;
      clear_inputs();
      n_checks++;
      if ({set_mode, adj_inc, adj_dec, run_en, blink} !== 6'b00_0011)
         $display("FAIL reset_outputs: got %b expected 000011", {set_mode, adj_inc, adj_dec, run_en, blink});
      else n_pass++;
   endtask

   task automatic test_mode_cycle();
      logic [1:0] exp_mode;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_mode = 2'(i + 1);
         mode_pulse();
         n_checks++;
         if (set_mode !== exp_mode || run_en !== (exp_mode != 2'd3))
            $display("FAIL mode_step%0d: got mode=%0d run_en=%0d expected mode=%0d run_en=%0d",
                     i, set_mode, run_en, exp_mode, (exp_mode != 2'd3));
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      do_reset();
      mode_pulse();
      mode_pulse();
      key_mode_pulse = 1'b1;
      key_up_pulse   = 1'b1;
      cyc();
      clear_inputs();
      n_checks++;
      if (set_mode !== 2'd3 || adj_inc !== 1'b0)
         $display("FAIL mode_over_up: got mode=%0d inc=%0d expected mode=3 inc=0", set_mode, adj_inc);
      else n_pass++;

      key_up_pulse   = 1'b1;
      key_down_pulse = 1'b1;
      cyc();
      clear_inputs();
      n_checks++;
      if (adj_inc !== 1'b1 || adj_dec !== 1'b0)
         $display("FAIL up_over_down: got inc=%0d dec=%0d expected inc=1 dec=0", adj_inc, adj_dec);
      else n_pass++;

      cyc();
      n_checks++;
      if (adj_inc !== 1'b0 || adj_dec !== 1'b0)
         $display("FAIL inc_single_cycle: got inc=%0d dec=%0d expected 0 0", adj_inc, adj_dec);
      else n_pass++;

      key_down_pulse = 1'b1;
      cyc();
      clear_inputs();
      n_checks++;
      if (adj_inc !== 1'b0 || adj_dec !== 1'b1 || set_mode !== 2'd3)
         $display("FAIL down_pulse: got inc=%0d dec=%0d mode=%0d expected 0 1 3", adj_inc, adj_dec, set_mode);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [1:0] exp_mode;
      do_reset();
      mode_pulse();
      for (int t = 1; t <= 3; t++) begin
         tick_1hz = 1'b1;
         cyc();
         tick_1hz = 1'b0;
         exp_mode = (t == 3) ? 2'd0 : 2'd1;
         n_checks++;
         if (set_mode !== exp_mode)
            $display("FAIL timeout_tick%0d: got mode=%0d expected %0d", t, set_mode, exp_mode);
         else n_pass++;
         cyc();
      end

      do_reset();
      mode_pulse();
      for (int t = 1; t <= 2; t++) begin
         tick_1hz = 1'b1;
         cyc();
         tick_1hz = 1'b0;
         cyc();
      end
      tick_1hz     = 1'b1;
      key_up_pulse = 1'b1;
      cyc();
      clear_inputs();
      n_checks++;
      if (set_mode !== 2'd1 || adj_inc !== 1'b1)
         $display("FAIL pulse_beats_timeout: got mode=%0d inc=%0d expected mode=1 inc=1", set_mode, adj_inc);
      else n_pass++;

      for (int t = 1; t <= 3; t++) begin
         tick_1hz = 1'b1;
         cyc();
         tick_1hz = 1'b0;
         exp_mode = (t == 3) ? 2'd0 : 2'd1;
         n_checks++;
         if (set_mode !== exp_mode)
            $display("FAIL timeout_restart_tick%0d: got mode=%0d expected %0d", t, set_mode, exp_mode);
         else n_pass++;
         cyc();
      end
   endtask

   task automatic test_blink();
      logic [8:0] exp_b;
      exp_b = 9'b1_0000_1111;
      do_reset();
      key_up_pulse = 1'b1;
      cyc();
      key_up_pulse   = 1'b0;
      key_down_pulse = 1'b1;
      cyc();
      key_down_pulse = 1'b0;
      n_checks++;
      if (adj_inc !== 1'b0 || adj_dec !== 1'b0 || blink !== 1'b1 || set_mode !== 2'd0)
         $display("FAIL normal_ignores_keys: got inc=%0d dec=%0d blink=%0d mode=%0d expected 0 0 1 0",
                  adj_inc, adj_dec, blink, set_mode);
      else n_pass++;

      mode_pulse();
      for (int i = 0; i < 9; i++) begin
         if (i > 0) cyc();
         n_checks++;
         if (blink !== exp_b[i])
            $display("FAIL blink_sample%0d: got %0d expected %0d", i, blink, exp_b[i]);
         else n_pass++;
      end

      for (int i = 0; i < 4; i++) cyc();
      n_checks++;
      if (blink !== 1'b0)
         $display("FAIL blink_before_reentry: got %0d expected 0", blink);
      else n_pass++;

      mode_pulse();
      n_checks++;
      if (blink !== 1'b1 || set_mode !== 2'd2)
         $display("FAIL blink_reentry: got blink=%0d mode=%0d expected 1 2", blink, set_mode);
      else n_pass++;

      for (int i = 0; i < 3; i++) cyc();
      n_checks++;
      if (blink !== 1'b1)
         $display("FAIL blink_reentry_hold: got %0d expected 1", blink);
      else n_pass++;
      cyc();
      n_checks++;
      if (blink !== 1'b0)
         $display("FAIL blink_reentry_toggle: got %0d expected 0", blink);
      else n_pass++;

      mode_pulse();
      mode_pulse();
      n_checks++;
      if (blink !== 1'b1 || set_mode !== 2'd0)
         $display("FAIL blink_normal: got blink=%0d mode=%0d expected 1 0", blink, set_mode);
      else n_pass++;
   endtask

   task automatic test_auto_repeat();
      logic exp_inc;
      do_reset();
      mode_pulse();
      mode_pulse();
      key_up_pulse = 1'b1;
      key_up_held  = 1'b1;
      for (int k = 1; k <= 26; k++) begin
         cyc();
         key_up_pulse = 1'b0;
         key_up_held  = (k < 20);
         exp_inc = (k == 1) || (REP_EN && (k == 10 || k == 13 || k == 16 || k == 19));
         n_checks++;
         if (adj_inc !== exp_inc || adj_dec !== 1'b0)
            $display("FAIL repeat_cycle%0d: got inc=%0d dec=%0d expected inc=%0d dec=0",
                     k, adj_inc, adj_dec, exp_inc);
         else n_pass++;
      end
      n_checks++;
      if (set_mode !== 2'd2)
         $display("FAIL repeat_mode_kept: got %0d expected 2", set_mode);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_repeat();
      do_reset();
      mode_pulse();
      mode_pulse();
      key_up_pulse = 1'b1;
      key_up_held  = 1'b1;
      cyc();
      key_up_pulse = 1'b0;
      n_checks++;
      if (adj_inc !== 1'b1)
         $display("FAIL mid_repeat_press: got inc=%0d expected 1", adj_inc);
      else n_pass++;
      for (int k = 2; k <= 9; k++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_checks++;
      if ({set_mode, adj_inc, adj_dec, run_en, blink} !== 6'b00_0011)
         $display("FAIL mid_repeat_reset: got %b expected 000011", {set_mode, adj_inc, adj_dec, run_en, blink});
      else n_pass++;

      mode_pulse();
      for (int k = 0; k < 15; k++) begin
         n_checks++;
         if (adj_inc !== 1'b0 || adj_dec !== 1'b0)
            $display("FAIL no_repeat_after_reset%0d: got inc=%0d dec=%0d expected 0 0", k, adj_inc, adj_dec);
         else n_pass++;
         cyc();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_mode_cycle();
      test_priority();
      test_timeout();
      test_blink();
      test_auto_repeat();
      test_reset_mid_repeat();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
